if_fetch_queue: RTL and testbench

- Instruction-fetch stage directly downstream of the program-counter register.
- Each cycle, takes the current word-addressed PC and issues a single-outstanding request to instruction memory.
- Captures each returned {pc, instruction} pair in a small FIFO, which presents them to decode with a valid/ready handshake.
- Drives pc_en back to the PC register so the PC advances only when a fetch is actually accepted; supports a flush for branch/jump redirects.

---
 rtl/if_pkg.sv | 26 ++
 rtl/if_fetch_queue_fifo.sv | 68 ++++++
 rtl/if_fetch_queue.sv | 119 +++++++++++
 tb/tb_if_fetch_queue.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch stage: fetch FSM states and the
// {pc, instr} record carried from memory response to decode.
package if_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic fetch_entry_t make_entry(input logic [XLEN-1:0] pc,
                                                input logic [XLEN-1:0] instr);
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        return e;
    endfunction

endpackage

// File: rtl/if_fetch_queue_fifo.sv
// Synchronous FIFO of fetch entries with clear; the head is read straight
// from storage, so a pushed entry becomes visible the cycle after the push.
module fetch_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_clear,
    input  logic                       i_push,
    input  fetch_entry_t               i_push_data,
    input  logic                       i_pop,
    output fetch_entry_t               o_head,
    output logic                       o_valid,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;

    assign w_empty = (r_count == '0);
    assign w_push  = i_push && (r_count != FULL_CNT);
    // Popping an empty FIFO is silently ignored.
    assign w_pop   = i_pop && !w_empty;

    // Entry storage; no reset needed since the head is masked while empty.
    always_ff @(posedge clk) begin
        if (w_push && !reset && !i_clear) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = !w_empty;
    assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: single-outstanding imem requests, response capture
// into a small FIFO toward decode, PC-advance feedback and redirect flush.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = if_pkg::XLEN
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [XLEN-1:0]            pc_in,
    output logic                       pc_en,
    input  logic                       flush,
    output logic                       imem_req_valid,
    output logic [XLEN-1:0]            imem_req_addr,
    input  logic                       imem_req_ready,
    input  logic                       imem_resp_valid,
    input  logic [XLEN-1:0]            imem_resp_data,
    output logic                       dec_valid,
    output logic [XLEN-1:0]            dec_instr,
    output logic [XLEN-1:0]            dec_pc,
    input  logic                       dec_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fetch_state_t  r_state;
    fetch_state_t  w_next_state;
    logic [XLEN-1:0] r_req_pc;
    logic          w_req_valid;
    logic          w_req_fire;
    logic          w_push;
    logic          w_pop;
    logic          w_head_valid;
    logic [CW-1:0] w_count;
    fetch_entry_t  w_head;

    // A request only issues with room guaranteed for its response.
    assign w_req_valid = !reset && !flush && (r_state == IDLE) && (w_count < FULL_CNT);
    assign w_req_fire  = w_req_valid && imem_req_ready;
    assign w_pop       = w_head_valid && dec_ready && !flush;

    // Next-state and push decision for the fetch FSM.
    always_comb begin
        w_next_state = r_state;
        w_push       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req_fire) begin
                    w_next_state = WAIT;
                end else begin
                    w_next_state = IDLE;
                end
            end
            WAIT: begin
                if (flush) begin
                    if (imem_resp_valid) begin
                        w_next_state = IDLE;
                    end else begin
                        w_next_state = DROP;
                    end
                end else if (imem_resp_valid) begin
                    w_push       = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_next_state = WAIT;
                end
            end
            DROP: begin
                if (imem_resp_valid) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = DROP;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // FSM state and the PC of the outstanding request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_req_pc <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_req_fire) begin
                r_req_pc <= pc_in;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (flush),
        .i_push      (w_push),
        .i_push_data (make_entry(r_req_pc, imem_resp_data)),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_valid     (w_head_valid),
        .o_count     (w_count)
    );

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = pc_in;
    assign pc_en          = w_req_fire;
    assign dec_valid      = w_head_valid;
    assign dec_instr      = w_head.instr;
    assign dec_pc         = w_head.pc;
    assign occupancy      = w_count;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed, table-driven bench for if_fetch_queue with DEPTH=2: one vector per cycle.
module tb_if_fetch_queue;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic        pc_en;
    logic        flush;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready;
    logic [1:0]  occupancy;

    int n_cmp;
    int n_bad;

    if_fetch_queue #(.DEPTH(2), .XLEN(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_in           (pc_in),
        .pc_en           (pc_en),
        .flush           (flush),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .dec_valid       (dec_valid),
        .dec_instr       (dec_instr),
        .dec_pc          (dec_pc),
        .dec_ready       (dec_ready),
        .occupancy       (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        rr;
        logic        rv;
        logic [31:0] rdata;
        logic        dr;
        logic [31:0] pc;
        logic        e_pcen;
        logic        e_reqv;
        logic        e_dv;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [1:0]  e_occ;
    } vec_t;

    vec_t vq[$];

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return 32'hC0DE_0000 ^ pc;
    endfunction

    function automatic vec_t mk(input logic rst, input logic fl, input logic rr,
                                input logic rv, input logic [31:0] rdata, input logic dr,
                                input logic [31:0] pc, input logic e_pcen, input logic e_reqv,
                                input logic e_dv, input logic [31:0] e_pc, input int e_occ);
        vec_t v;
        v.rst = rst; v.fl = fl; v.rr = rr; v.rv = rv; v.rdata = rdata; v.dr = dr; v.pc = pc;
        v.e_pcen = e_pcen; v.e_reqv = e_reqv; v.e_dv = e_dv;
        v.e_pc    = e_dv ? e_pc : 32'h0;
        v.e_instr = e_dv ? ins(e_pc) : 32'h0;
        v.e_occ   = 2'(e_occ);
        return v;
    endfunction

    task automatic chk(input string tag, input string what,
                       input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s %s: got %h expected %h", tag, what, got, exp);
        end
    endtask

    // Drive one cycle of inputs just after the edge, compare before the next edge.
    task automatic apply(input vec_t v, input string tag);
        @(posedge clk);
        #1;
        reset           = v.rst;
        flush           = v.fl;
        imem_req_ready  = v.rr;
        imem_resp_valid = v.rv;
        imem_resp_data  = v.rdata;
        dec_ready       = v.dr;
        pc_in           = v.pc;
        #2;
        chk(tag, "pc_en",     {31'h0, pc_en},          {31'h0, v.e_pcen});
        chk(tag, "req_valid", {31'h0, imem_req_valid}, {31'h0, v.e_reqv});
        chk(tag, "req_addr",  imem_req_addr,           v.pc);
        chk(tag, "dec_valid", {31'h0, dec_valid},      {31'h0, v.e_dv});
        chk(tag, "dec_pc",    dec_pc,                  v.e_pc);
        chk(tag, "dec_instr", dec_instr,               v.e_instr);
        chk(tag, "occupancy", {30'h0, occupancy},      {30'h0, v.e_occ});
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clk = 1'b0;
        reset = 1'b1;
        flush = 1'b0;
        pc_in = 32'h0;
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data = 32'h0;
        dec_ready = 1'b0;
        repeat (2) @(posedge clk);

        // rst fl rr rv rdata dr pc | pc_en req_valid dec_valid dec_pc occ
        // Streaming with one-cycle memory latency.
        vq.push_back(mk(1'b1,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,   1'b0,1'b0,1'b0,32'h0,0));
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b0,32'h0,1'b1,32'h0,   1'b1,1'b1,1'b0,32'h0,0));
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b1,ins(32'h0),1'b1,32'h1, 1'b0,1'b0,1'b0,32'h0,0));
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b0,32'h0,1'b1,32'h1,   1'b1,1'b1,1'b1,32'h0,1));
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b1,ins(32'h1),1'b1,32'h2, 1'b0,1'b0,1'b0,32'h0,0));
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b0,32'h0,1'b1,32'h2,   1'b1,1'b1,1'b1,32'h1,1));
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b1,ins(32'h2),1'b1,32'h3, 1'b0,1'b0,1'b0,32'h0,0));
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b0,32'h0,1'b1,32'h3,   1'b1,1'b1,1'b1,32'h2,1));
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b1,ins(32'h3),1'b0,32'h4, 1'b0,1'b0,1'b0,32'h0,0));
        vq.push_back(mk(1'b1,1'b0,1'b1,1'b0,32'h0,1'b0,32'h4,   1'b0,1'b0,1'b1,32'h3,1));
        // Backpressure: fill both entries, then release one pop.
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b0,32'h0,1'b0,32'h10,  1'b1,1'b1,1'b0,32'h0,0));
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b1,ins(32'h10),1'b0,32'h11, 1'b0,1'b0,1'b0,32'h0,0));
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b0,32'h0,1'b0,32'h11,  1'b1,1'b1,1'b1,32'h10,1));
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b1,ins(32'h11),1'b0,32'h12, 1'b0,1'b0,1'b1,32'h10,1));
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b0,32'h0,1'b0,32'h12,  1'b0,1'b0,1'b1,32'h10,2));
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b0,32'h0,1'b0,32'h12,  1'b0,1'b0,1'b1,32'h10,2));
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b0,32'h0,1'b1,32'h12,  1'b0,1'b0,1'b1,32'h10,2));
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b0,32'h0,1'b0,32'h12,  1'b1,1'b1,1'b1,32'h11,1));
        // Simultaneous push and pop at occupancy 1.
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b1,ins(32'h12),1'b1,32'h13, 1'b0,1'b0,1'b1,32'h11,1));
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b0,32'h0,1'b0,32'h13,  1'b1,1'b1,1'b1,32'h12,1));
        // Flush in WAIT, response arrives three cycles later and is dropped.
        vq.push_back(mk(1'b0,1'b1,1'b1,1'b0,32'h0,1'b0,32'h14,  1'b0,1'b0,1'b1,32'h12,1));
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b0,32'h0,1'b0,32'h40,  1'b0,1'b0,1'b0,32'h0,0));
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b0,32'h0,1'b0,32'h40,  1'b0,1'b0,1'b0,32'h0,0));
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b1,ins(32'h13),1'b0,32'h40, 1'b0,1'b0,1'b0,32'h0,0));
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b0,32'h0,1'b1,32'h40,  1'b1,1'b1,1'b0,32'h0,0));
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b1,ins(32'h40),1'b1,32'h41, 1'b0,1'b0,1'b0,32'h0,0));
        // Memory stall: request valid but not accepted, PC must hold.
        vq.push_back(mk(1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h41,  1'b0,1'b1,1'b1,32'h40,1));
        // Flush coincident with the response.
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b0,32'h0,1'b0,32'h41,  1'b1,1'b1,1'b1,32'h40,1));
        vq.push_back(mk(1'b0,1'b1,1'b1,1'b1,ins(32'h41),1'b0,32'h42, 1'b0,1'b0,1'b1,32'h40,1));
        // Pop on empty is ignored.
        vq.push_back(mk(1'b0,1'b0,1'b0,1'b0,32'h0,1'b1,32'h50,  1'b0,1'b1,1'b0,32'h0,0));
        vq.push_back(mk(1'b0,1'b0,1'b0,1'b0,32'h0,1'b1,32'h50,  1'b0,1'b1,1'b0,32'h0,0));
        // Flush in IDLE blocks issue; stray response in IDLE is not pushed.
        vq.push_back(mk(1'b0,1'b1,1'b1,1'b0,32'h0,1'b0,32'h50,  1'b0,1'b0,1'b0,32'h0,0));
        vq.push_back(mk(1'b0,1'b0,1'b0,1'b1,32'hDEAD_BEEF,1'b0,32'h50, 1'b0,1'b1,1'b0,32'h0,0));
        vq.push_back(mk(1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h50,  1'b0,1'b1,1'b0,32'h0,0));

        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i], $sformatf("vec%0d", i));
        end

        // Reset while a request is outstanding with an entry queued, then a stale response.
        apply(mk(1'b0,1'b0,1'b1,1'b0,32'h0,1'b0,32'h60, 1'b1,1'b1,1'b0,32'h0,0), "rstw_issue0");
        apply(mk(1'b0,1'b0,1'b1,1'b1,ins(32'h60),1'b0,32'h61, 1'b0,1'b0,1'b0,32'h0,0), "rstw_resp0");
        apply(mk(1'b0,1'b0,1'b1,1'b0,32'h0,1'b0,32'h61, 1'b1,1'b1,1'b1,32'h60,1), "rstw_issue1");
        apply(mk(1'b1,1'b0,1'b1,1'b0,32'h0,1'b0,32'h62, 1'b0,1'b0,1'b1,32'h60,1), "rstw_reset");
        apply(mk(1'b0,1'b0,1'b0,1'b1,ins(32'h61),1'b0,32'h0, 1'b0,1'b1,1'b0,32'h0,0), "rstw_stale");
        apply(mk(1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0, 1'b0,1'b1,1'b0,32'h0,0), "rstw_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
